sys_cmd_ctrl: RTL
=================

Name: sys_cmd_ctrl

Overview:
- Command-decoding initiator that drives the configuration register file from UART RX bytes and returns read data through UART TX.
- Parses byte-serial frames, issues single-cycle write/read strobes to the register file and serialises the 16-bit read word back as two bytes.
- Sits between the UART RX/TX byte interfaces and the register file, in the register-file clock domain.

Parameters:
- ADDR_WD, 3, register file address width; address byte bits [7:ADDR_WD] must be zero.
- DATA_WD, 16, register file data width; fixed at 16, so two bytes per word.
- TIMEOUT_CYC, 1024, inter-byte timeout in CLK cycles (used only with the optional feature).

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  asynchronous active-low reset.
- RX_P_DATA  in  8  received byte.
- RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA valid.
- WrEn  out  1  register-file write strobe.
- RdEn  out  1  register-file read strobe.
- Address  out  ADDR_WD  register-file address.
- WrData  out  DATA_WD  register-file write data.
- RdData  in  DATA_WD  register-file read data; valid the cycle after RdEn.
- TX_P_DATA  out  8  byte to transmit.
- TX_D_VLD  out  1  TX request, held until accepted.
- TX_Busy  in  1  UART TX busy.
- CMD_BUSY  out  1  high whenever the FSM is not in IDLE.
- CMD_ERR  out  1  one-cycle pulse on a rejected frame.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, internal latches cleared. Reset mid-frame aborts immediately with no strobe issued.
- All outputs are registered.
- Write frame: 0xAA, ADDR, DATA_LSB, DATA_MSB.
- Read frame: 0xBB, ADDR.
- In IDLE, RX_D_VLD with a byte other than 0xAA/0xBB is ignored silently, with no CMD_ERR.
- FSM states: IDLE, WR_ADDR, WR_LSB, WR_MSB, WR_EXEC, RD_ADDR, RD_EXEC, RD_CAPT, TX_LSB, TX_LSB_WAIT, TX_MSB, TX_MSB_WAIT.
- Byte-collecting states advance only on RX_D_VLD.
- ADDR byte with any bit [7:ADDR_WD] set: CMD_ERR pulses 1 cycle, FSM returns to IDLE, no strobe issued.
- WR_EXEC: WrEn=1 for exactly one cycle, with Address and WrData={MSB,LSB} valid that cycle; RdEn=0; then IDLE.
  - Latency: WrEn is asserted on the 2nd rising edge after the RX_D_VLD cycle of DATA_MSB.
- RD_EXEC: RdEn=1 for exactly one cycle; WrEn=0.
- RD_CAPT: RdData is latched into an internal 16-bit register on the cycle after RdEn.
- TX_LSB: TX_P_DATA=RdData[7:0]; TX_D_VLD is raised only when TX_Busy=0, and held with the data stable until TX_Busy=1 is sampled. TX_D_VLD then drops the next cycle and the FSM enters TX_LSB_WAIT.
- TX_LSB_WAIT: wait for TX_Busy=0, then go to TX_MSB.
- TX_MSB / TX_MSB_WAIT: same handshake with RdData[15:8]; return to IDLE after TX_Busy=0.
- RX_D_VLD in any RD_EXEC…TX_MSB_WAIT state is dropped, with no CMD_ERR.
- WrEn and RdEn are never high together.
- Address is held from the ADDR byte until the next ADDR byte.
- CMD_BUSY = (state != IDLE).

Optional Feature:
- Macro: SYS_CMD_TIMEOUT_EN.
- Defined: a counter clears on every RX_D_VLD and counts in WR_ADDR, WR_LSB, WR_MSB and RD_ADDR. On reaching TIMEOUT_CYC-1 without a byte, CMD_ERR pulses 1 cycle and the FSM returns to IDLE with no strobe. The counter is idle in all other states.
- Not defined: no counter; the FSM waits indefinitely for the next frame byte.

Test Plan:
- Reset mid-frame: send 0xAA,0x05; assert RST low for 1 cycle -> all outputs 0, state IDLE; a following 0xBB,0x05 executes normally.
- Write: RX 0xAA,0x05,0x34,0x12 -> exactly one WrEn cycle with Address=5, WrData=0x1234, RdEn=0; no TX activity.
- Read: preload reg 3=0x0020; RX 0xBB,0x03 -> one RdEn cycle with Address=3; then TX bytes 0x20 then 0x00, each TX_D_VLD held until TX_Busy rises; with TX_Busy held 1 at start, TX_D_VLD stays 0 until TX_Busy falls.
- Bad address: RX 0xAA,0x0C -> CMD_ERR 1-cycle pulse, no WrEn; the next frame 0xAA,0x01,0xFF,0x00 writes 0x00FF to reg 1.
- Unknown/overlap: RX 0x55 in IDLE -> no response, no CMD_ERR; during read response RX 0xAA -> ignored and response completes.
- SYS_CMD_TIMEOUT_EN (TIMEOUT_CYC=16): RX 0xAA,0x02, then 16 idle cycles -> CMD_ERR pulse, IDLE, no WrEn. Without the macro, a later 0x11,0x22 completes the write of 0x2211.

Source files
------------

// File: rtl/sys_cmd_ctrl.sv
// UART byte-command decoder: write/read frames to a register file, read word returned as two TX bytes.
// Optional inter-byte timeout enabled by defining SYS_CMD_TIMEOUT_EN.
`timescale 1ns/1ps
module sys_cmd_ctrl #(
   parameter int ADDR_WD     = 3,
   parameter int DATA_WD     = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [7:0]         RX_P_DATA,
   input  logic               RX_D_VLD,
   output logic               WrEn,
   output logic               RdEn,
   output logic [ADDR_WD-1:0] Address,
   output logic [DATA_WD-1:0] WrData,
   input  logic [DATA_WD-1:0] RdData,
   output logic [7:0]         TX_P_DATA,
   output logic               TX_D_VLD,
   input  logic               TX_Busy,
   output logic               CMD_BUSY,
   output logic               CMD_ERR
);

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_LSB, WR_MSB, WR_EXEC, RD_ADDR, RD_EXEC, RD_CAPT,
      TX_LSB, TX_LSB_WAIT, TX_MSB, TX_MSB_WAIT
   } state_t;

   state_t               r_state, w_next;
   logic                 r_wr_en, r_rd_en, r_busy, r_err, r_tx_vld;
   logic [ADDR_WD-1:0]   r_addr;
   logic [7:0]           r_lsb;
   logic [DATA_WD-1:0]   r_wr_data, r_rd_data;
   logic [7:0]           r_tx_data;
   logic                 w_err, w_tx_vld, w_addr_ok, w_to_hit;

   assign w_addr_ok = (RX_P_DATA[7:ADDR_WD] == '0);

`ifdef SYS_CMD_TIMEOUT_EN
   localparam int TO_WD = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [TO_WD-1:0] r_to_cnt;
   logic             w_collect;

   assign w_collect = (r_state == WR_ADDR) || (r_state == WR_LSB) ||
                      (r_state == WR_MSB)  || (r_state == RD_ADDR);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         r_to_cnt <= '0;
      else if (RX_D_VLD || !w_collect)
         r_to_cnt <= '0;
      else
         r_to_cnt <= r_to_cnt + 1'b1;
   end

   assign w_to_hit = w_collect && !RX_D_VLD && (r_to_cnt == TO_WD'(TIMEOUT_CYC - 1));
`else
   assign w_to_hit = 1'b0;
`endif

   always_comb begin
      w_next   = r_state;
      w_err    = 1'b0;
      w_tx_vld = r_tx_vld;
      case (r_state)
         IDLE:
            if (RX_D_VLD) begin
               if (RX_P_DATA == 8'hAA)      w_next = WR_ADDR;
               else if (RX_P_DATA == 8'hBB) w_next = RD_ADDR;
            end
         WR_ADDR:
            if (RX_D_VLD) begin
               if (w_addr_ok) w_next = WR_LSB;
               else begin w_next = IDLE; w_err = 1'b1; end
            end
         WR_LSB:  if (RX_D_VLD) w_next = WR_MSB;
         WR_MSB:  if (RX_D_VLD) w_next = WR_EXEC;
         WR_EXEC: w_next = IDLE;
         RD_ADDR:
            if (RX_D_VLD) begin
               if (w_addr_ok) w_next = RD_EXEC;
               else begin w_next = IDLE; w_err = 1'b1; end
            end
         RD_EXEC: w_next = RD_CAPT;
         RD_CAPT: w_next = TX_LSB;
         // Request is raised only while TX is idle and dropped once busy is seen.
         TX_LSB, TX_MSB:
            if (r_tx_vld) begin
               if (TX_Busy) begin
                  w_tx_vld = 1'b0;
                  w_next   = (r_state == TX_LSB) ? TX_LSB_WAIT : TX_MSB_WAIT;
               end
            end else if (!TX_Busy) begin
               w_tx_vld = 1'b1;
            end
         TX_LSB_WAIT: if (!TX_Busy) w_next = TX_MSB;
         TX_MSB_WAIT: if (!TX_Busy) w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (w_to_hit) begin
         w_next = IDLE;
         w_err  = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= IDLE;
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
         r_tx_vld  <= 1'b0;
         r_addr    <= '0;
         r_lsb     <= '0;
         r_wr_data <= '0;
         r_rd_data <= '0;
         r_tx_data <= '0;
      end else begin
         r_state  <= w_next;
         r_err    <= w_err;
         r_busy   <= (w_next != IDLE);
         r_tx_vld <= w_tx_vld;
         // Write strobe lands one cycle after WR_EXEC; read strobe coincides with RD_EXEC.
         r_wr_en  <= (r_state == WR_EXEC);
         r_rd_en  <= (w_next == RD_EXEC);
         if ((r_state == WR_ADDR || r_state == RD_ADDR) && RX_D_VLD && w_addr_ok)
            r_addr <= RX_P_DATA[ADDR_WD-1:0];
         if (r_state == WR_LSB && RX_D_VLD)
            r_lsb <= RX_P_DATA;
         if (r_state == WR_MSB && RX_D_VLD)
            r_wr_data <= {RX_P_DATA, r_lsb};
         if (r_state == RD_CAPT)
            r_rd_data <= RdData;
         if (r_state == TX_LSB)
            r_tx_data <= r_rd_data[7:0];
         else if (r_state == TX_MSB)
            r_tx_data <= r_rd_data[15:8];
      end
   end

   assign WrEn      = r_wr_en;
   assign RdEn      = r_rd_en;
   assign Address   = r_addr;
   assign WrData    = r_wr_data;
   assign TX_P_DATA = r_tx_data;
   assign TX_D_VLD  = r_tx_vld;
   assign CMD_BUSY  = r_busy;
   assign CMD_ERR   = r_err;

endmodule
